// File: rtl/outer_seq.sv
// ============================================================================
// Module   : outer_seq
// Purpose  : Outer interpreter sequencer. Walks the terminal input buffer one
//            token at a time: looks each token up in the dictionary, then
//            executes it, compiles it as a cell, or parses it as a number that
//            is pushed or compiled as a literal.
// Ports    : clk/rst          clock, asynchronous active-high reset
//            en               run enable (low returns to IDLE)
//            tib_len/hex/ctx0/here0  run setup, parser radix
//            cmp_set/cmp_clr  compile-flag pulses (clear wins)
//            fdr_*            dictionary finder handshake
//            a2i_*            number parser handshake
//            exe_*            word executor handshake
//            psh_*            data stack push handshake
//            mem_*            dictionary byte write port
//            tib/here/cmp/bsy/err/err_code  status
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module outer_seq #(
    parameter int unsigned TIB    = 'h0,
    parameter int unsigned DSZ    = 8,
    parameter int unsigned ASZ    = 17,
    parameter int unsigned NB     = 4,
    parameter int unsigned OP_LIT = 'h01,
    parameter int unsigned HMAX   = 'h1FFFF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    input  logic [ASZ-1:0] tib_len,
    input  logic           hex,
    input  logic [ASZ-1:0] ctx0,
    input  logic [ASZ-1:0] here0,
    input  logic           cmp_set,
    input  logic           cmp_clr,
    output logic           fdr_req,
    output logic [ASZ-1:0] fdr_aw,
    output logic [ASZ-1:0] fdr_ctx,
    input  logic           fdr_done,
    input  logic           fdr_hit,
    input  logic           fdr_imm,
    input  logic [ASZ-1:0] fdr_pfa,
    input  logic [ASZ-1:0] fdr_tib,
    output logic           a2i_req,
    output logic [ASZ-1:0] a2i_ai,
    output logic           a2i_hex,
    input  logic           a2i_done,
    input  logic           a2i_err,
    input  logic [31:0]    a2i_val,
    input  logic [ASZ-1:0] a2i_tib,
    output logic           exe_req,
    output logic [ASZ-1:0] exe_pfa,
    input  logic           exe_done,
    output logic           psh_req,
    output logic [31:0]    psh_val,
    input  logic           psh_ack,
    output logic           mem_we,
    output logic [ASZ-1:0] mem_ai,
    output logic [DSZ-1:0] mem_vi,
    output logic [ASZ-1:0] tib,
    output logic [ASZ-1:0] here,
    output logic           cmp,
    output logic           bsy,
    output logic           err,
    output logic [1:0]     err_code
);

    localparam logic [ASZ-1:0] c_tib  = ASZ'(TIB);
    localparam int             c_ww   = NB * DSZ;
    localparam int             c_iw   = $clog2(NB + 2);
    localparam logic [ASZ+1:0] c_hmax = (ASZ+2)'(HMAX);
    localparam logic [DSZ-1:0] c_lit  = DSZ'(OP_LIT);
    localparam logic [c_iw-1:0] c_cma_last = c_iw'(NB - 1);
    localparam logic [c_iw-1:0] c_num_last = c_iw'(NB);

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_CHK  = 4'd1,
        S_FND  = 4'd2,
        S_EXE  = 4'd3,
        S_CMA  = 4'd4,
        S_A2I  = 4'd5,
        S_NUM  = 4'd6,
        S_PSH  = 4'd7,
        S_DONE = 4'd8,
        S_ERR  = 4'd9
    } state_t;

    state_t          r_state;
    logic [ASZ-1:0]  r_tib;
    logic [ASZ-1:0]  r_here;
    logic [ASZ-1:0]  r_ctx;
    logic [ASZ-1:0]  r_tok;
    logic [ASZ-1:0]  r_pfa;
    logic [31:0]     r_val;
    logic            r_cmp;
    logic [c_iw-1:0] r_idx;
    logic [1:0]      r_err_code;

    logic            w_at_end;
    logic            w_ovf_cma;
    logic            w_ovf_num;
    logic [c_ww-1:0] w_word;
    logic [c_iw-1:0] w_sel;
    logic [DSZ-1:0]  w_byte;

    // Widened arithmetic so end-of-buffer and dictionary-limit tests never wrap.
    assign w_at_end  = {1'b0, r_tib} >= ({1'b0, c_tib} + {1'b0, tib_len});
    assign w_ovf_cma = ({2'b00, r_here} + (ASZ+2)'(NB - 1)) > c_hmax;
    assign w_ovf_num = ({2'b00, r_here} + (ASZ+2)'(NB)) > c_hmax;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_tib      <= c_tib;
            r_here     <= '0;
            r_ctx      <= '0;
            r_tok      <= '0;
            r_pfa      <= '0;
            r_val      <= '0;
            r_cmp      <= 1'b0;
            r_idx      <= '0;
            r_err_code <= 2'd0;
        end else begin
            if (!en) begin
                r_state <= S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_tib      <= c_tib;
                        r_here     <= here0;
                        r_ctx      <= ctx0;
                        r_cmp      <= 1'b0;
                        r_err_code <= 2'd0;
                        r_state    <= S_CHK;
                    end
                    S_CHK: begin
                        if (w_at_end) begin
                            r_state <= S_DONE;
                        end else begin
                            r_tok   <= r_tib;
                            r_state <= S_FND;
                        end
                    end
                    S_FND: begin
                        if (fdr_done) begin
                            r_tib <= fdr_tib;
                            r_pfa <= fdr_pfa;
                            r_idx <= '0;
                            if (fdr_hit && r_cmp && !fdr_imm) begin
                                if (w_ovf_cma) begin
                                    r_err_code <= 2'd2;
                                    r_state    <= S_ERR;
                                end else begin
                                    r_state <= S_CMA;
                                end
                            end else if (fdr_hit) begin
                                r_state <= S_EXE;
                            end else begin
                                r_state <= S_A2I;
                            end
                        end
                    end
                    S_EXE: begin
                        if (exe_done) r_state <= S_CHK;
                    end
                    S_CMA: begin
                        r_here <= r_here + 1'b1;
                        r_idx  <= r_idx + 1'b1;
                        if (r_idx == c_cma_last) r_state <= S_CHK;
                    end
                    S_A2I: begin
                        if (a2i_done) begin
                            r_idx <= '0;
                            if (a2i_err) begin
                                r_err_code <= 2'd1;
                                r_state    <= S_ERR;
                            end else begin
                                r_tib <= a2i_tib;
                                r_val <= a2i_val;
                                if (!r_cmp) begin
                                    r_state <= S_PSH;
                                end else if (w_ovf_num) begin
                                    r_err_code <= 2'd2;
                                    r_state    <= S_ERR;
                                end else begin
                                    r_state <= S_NUM;
                                end
                            end
                        end
                    end
                    S_NUM: begin
                        r_here <= r_here + 1'b1;
                        r_idx  <= r_idx + 1'b1;
                        if (r_idx == c_num_last) r_state <= S_CHK;
                    end
                    S_PSH: begin
                        if (psh_ack) r_state <= S_CHK;
                    end
                    S_DONE, S_ERR: r_state <= r_state;
                    default: r_state <= S_IDLE;
                endcase
            end
            // Placed after the state case so a pulse overrides the IDLE load.
            if (cmp_clr) begin
                r_cmp <= 1'b0;
            end else if (cmp_set) begin
                r_cmp <= 1'b1;
            end
        end
    end

    // Byte lane select: CMA emits pfa bytes 0..NB-1, NUM emits the literal
    // opcode at index 0 followed by val bytes 0..NB-1.
    always_comb begin
        w_word = (r_state == S_CMA) ? c_ww'(r_pfa) : c_ww'(r_val);
        w_sel  = (r_state == S_NUM) ? (r_idx - 1'b1) : r_idx;
        w_byte = '0;
        for (int k = 0; k < int'(NB); k++) begin
            if (w_sel == c_iw'(k)) w_byte = w_word[k*DSZ +: DSZ];
        end
    end

    // All handshake outputs decode from state, so no done/ack reaches a req
    // combinationally and at most one request is ever active.
    assign fdr_req  = (r_state == S_FND);
    assign a2i_req  = (r_state == S_A2I);
    assign exe_req  = (r_state == S_EXE);
    assign psh_req  = (r_state == S_PSH);
    assign mem_we   = (r_state == S_CMA) || (r_state == S_NUM);
    assign mem_ai   = mem_we ? r_here : '0;
    assign mem_vi   = !mem_we ? '0 :
                      ((r_state == S_NUM) && (r_idx == '0)) ? c_lit : w_byte;
    assign fdr_aw   = r_tok;
    assign fdr_ctx  = r_ctx;
    assign a2i_ai   = r_tok;
    assign a2i_hex  = hex;
    assign exe_pfa  = r_pfa;
    assign psh_val  = r_val;
    assign tib      = r_tib;
    assign here     = r_here;
    assign cmp      = r_cmp;
    assign bsy      = !((r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERR));
    assign err      = (r_state == S_ERR);
    assign err_code = (r_state == S_ERR) ? r_err_code : 2'd0;

endmodule

`default_nettype wire

// File: tb/tb_outer_seq.sv
// ============================================================================
// Module   : tb_outer_seq
// Purpose  : Self-checking bench for outer_seq. Expected dictionary writes are
//            queued when a compiling token is driven and compared as the DUT
//            presents them. A second instance with a low HMAX shares all inputs
//            to exercise the dictionary-limit path.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_outer_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [16:0] tib_len, ctx0, here0;
    logic        hex, cmp_set, cmp_clr;
    logic        fdr_done, fdr_hit, fdr_imm;
    logic [16:0] fdr_pfa, fdr_tib;
    logic        a2i_done, a2i_err;
    logic [31:0] a2i_val;
    logic [16:0] a2i_tib;
    logic        exe_done, psh_ack;

    logic        fdr_req, a2i_req, a2i_hex, exe_req, psh_req, mem_we;
    logic [16:0] fdr_aw, fdr_ctx, a2i_ai, exe_pfa, mem_ai, tib, here;
    logic [31:0] psh_val;
    logic [7:0]  mem_vi;
    logic        cmp, bsy, err;
    logic [1:0]  err_code;

    logic        ovf_fdr_req, ovf_a2i_req, ovf_a2i_hex, ovf_exe_req, ovf_psh_req, ovf_mem_we;
    logic [16:0] ovf_fdr_aw, ovf_fdr_ctx, ovf_a2i_ai, ovf_exe_pfa, ovf_mem_ai, ovf_tib, ovf_here;
    logic [31:0] ovf_psh_val;
    logic [7:0]  ovf_mem_vi;
    logic        ovf_cmp, ovf_bsy, ovf_err;
    logic [1:0]  ovf_err_code;

    int n_chk = 0;
    int n_pass = 0;
    int n_fdr = 0;
    int n_psh = 0;
    int n_ovf_we = 0;
    logic [24:0] sb[$];

    always #5 clk = ~clk;

    outer_seq u_dut (
        .clk(clk), .rst(rst), .en(en), .tib_len(tib_len), .hex(hex), .ctx0(ctx0), .here0(here0),
        .cmp_set(cmp_set), .cmp_clr(cmp_clr),
        .fdr_req(fdr_req), .fdr_aw(fdr_aw), .fdr_ctx(fdr_ctx), .fdr_done(fdr_done), .fdr_hit(fdr_hit),
        .fdr_imm(fdr_imm), .fdr_pfa(fdr_pfa), .fdr_tib(fdr_tib),
        .a2i_req(a2i_req), .a2i_ai(a2i_ai), .a2i_hex(a2i_hex), .a2i_done(a2i_done), .a2i_err(a2i_err),
        .a2i_val(a2i_val), .a2i_tib(a2i_tib),
        .exe_req(exe_req), .exe_pfa(exe_pfa), .exe_done(exe_done),
        .psh_req(psh_req), .psh_val(psh_val), .psh_ack(psh_ack),
        .mem_we(mem_we), .mem_ai(mem_ai), .mem_vi(mem_vi),
        .tib(tib), .here(here), .cmp(cmp), .bsy(bsy), .err(err), .err_code(err_code)
    );

    outer_seq #(.HMAX('h203)) u_ovf (
        .clk(clk), .rst(rst), .en(en), .tib_len(tib_len), .hex(hex), .ctx0(ctx0), .here0(here0),
        .cmp_set(cmp_set), .cmp_clr(cmp_clr),
        .fdr_req(ovf_fdr_req), .fdr_aw(ovf_fdr_aw), .fdr_ctx(ovf_fdr_ctx), .fdr_done(fdr_done),
        .fdr_hit(fdr_hit), .fdr_imm(fdr_imm), .fdr_pfa(fdr_pfa), .fdr_tib(fdr_tib),
        .a2i_req(ovf_a2i_req), .a2i_ai(ovf_a2i_ai), .a2i_hex(ovf_a2i_hex), .a2i_done(a2i_done),
        .a2i_err(a2i_err), .a2i_val(a2i_val), .a2i_tib(a2i_tib),
        .exe_req(ovf_exe_req), .exe_pfa(ovf_exe_pfa), .exe_done(exe_done),
        .psh_req(ovf_psh_req), .psh_val(ovf_psh_val), .psh_ack(psh_ack),
        .mem_we(ovf_mem_we), .mem_ai(ovf_mem_ai), .mem_vi(ovf_mem_vi),
        .tib(ovf_tib), .here(ovf_here), .cmp(ovf_cmp), .bsy(ovf_bsy), .err(ovf_err),
        .err_code(ovf_err_code)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    // Write monitor / scoreboard consumer, plus request activity counters.
    always @(negedge clk) begin
        if (!rst) begin
            if (fdr_req) n_fdr++;
            if (psh_req) n_psh++;
            if (ovf_mem_we) n_ovf_we++;
            if (mem_we) begin
                if (sb.size() == 0) begin
                    check("mem_we_unexpected", {47'd0, mem_ai}, 64'h1_FFFF_FFFF);
                end else begin
                    logic [24:0] e;
                    e = sb.pop_front();
                    check("mem_ai", mem_ai, e[24:8]);
                    check("mem_vi", mem_vi, e[7:0]);
                end
            end
        end
    end

    function automatic logic sig(input int w);
        case (w)
            0: return fdr_req;
            1: return a2i_req;
            2: return exe_req;
            3: return psh_req;
            4: return !bsy;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_for(input string tag, input int w);
        int i;
        i = 0;
        while (!sig(w) && i < 60) begin
            @(negedge clk);
            i++;
        end
        check(tag, sig(w), 1);
    endtask

    task automatic fdr(input logic h, input logic im, input logic [16:0] p, input logic [16:0] t);
        fdr_hit = h; fdr_imm = im; fdr_pfa = p; fdr_tib = t; fdr_done = 1'b1;
        @(negedge clk);
        fdr_done = 1'b0;
    endtask

    task automatic a2i(input logic e, input logic [31:0] v, input logic [16:0] t);
        a2i_err = e; a2i_val = v; a2i_tib = t; a2i_done = 1'b1;
        @(negedge clk);
        a2i_done = 1'b0;
    endtask

    task automatic exe_ack();
        exe_done = 1'b1;
        @(negedge clk);
        exe_done = 1'b0;
    endtask

    task automatic psh_pulse();
        psh_ack = 1'b1;
        @(negedge clk);
        psh_ack = 1'b0;
    endtask

    task automatic set_pulse();
        cmp_set = 1'b1;
        @(negedge clk);
        cmp_set = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        en  = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        n_fdr = 0; n_psh = 0; n_ovf_we = 0;
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic start(input logic [16:0] len, input logic [16:0] h0, input logic [16:0] c0);
        tib_len = len; here0 = h0; ctx0 = c0; en = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; en = 1'b0; tib_len = '0; ctx0 = '0; here0 = '0; hex = 1'b0;
        cmp_set = 1'b0; cmp_clr = 1'b0; fdr_done = 1'b0; fdr_hit = 1'b0; fdr_imm = 1'b0;
        fdr_pfa = '0; fdr_tib = '0; a2i_done = 1'b0; a2i_err = 1'b0; a2i_val = '0; a2i_tib = '0;
        exe_done = 1'b0; psh_ack = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_bsy", bsy, 0);
        check("rst_tib", tib, 0);
        check("rst_here", here, 0);
        check("rst_req", {fdr_req, a2i_req, exe_req, psh_req, mem_we}, 0);
        check("rst_mem", {mem_ai, mem_vi}, 0);
        check("rst_err", {err, err_code, cmp}, 0);

        // Interpret a found word
        do_reset();
        start(4, 'h100, 'h55);
        wait_for("s1_fdr_req", 0);
        check("s1_fdr_aw", fdr_aw, 0);
        check("s1_fdr_ctx", fdr_ctx, 'h55);
        check("s1_bsy", bsy, 1);
        fdr(1, 0, 'h120, 4);
        check("s1_fdr_drop", fdr_req, 0);
        check("s1_exe_req", exe_req, 1);
        check("s1_exe_pfa", exe_pfa, 'h120);
        exe_ack();
        wait_for("s1_done", 4);
        check("s1_tib", tib, 4);
        check("s1_err", err, 0);

        // Empty buffer
        do_reset();
        start(0, 'h10, 0);
        wait_for("s0_done", 4);
        check("s0_no_fdr", n_fdr, 0);

        // Compile literal (also drives the low-HMAX instance into overflow)
        do_reset();
        hex = 1'b1;
        start(4, 'h200, 0);
        wait_for("s2_fdr_req", 0);
        set_pulse();
        check("s2_cmp", cmp, 1);
        sb.push_back({17'h200, 8'h01});
        sb.push_back({17'h201, 8'h78});
        sb.push_back({17'h202, 8'h56});
        sb.push_back({17'h203, 8'h34});
        sb.push_back({17'h204, 8'h12});
        fdr(0, 0, 0, 2);
        wait_for("s2_a2i_req", 1);
        check("s2_a2i_ai", a2i_ai, 0);
        check("s2_a2i_hex", a2i_hex, 1);
        a2i(0, 'h12345678, 4);
        wait_for("s2_done", 4);
        check("s2_here", here, 'h205);
        check("s2_sb_empty", sb.size(), 0);
        check("ovf_err", ovf_err, 1);
        check("ovf_code", ovf_err_code, 2);
        check("ovf_bsy", ovf_bsy, 0);
        check("ovf_here", ovf_here, 'h200);
        check("ovf_no_we", n_ovf_we, 0);
        hex = 1'b0;

        // Compile word, then the same word flagged immediate
        do_reset();
        start(8, 'h300, 0);
        set_pulse();
        wait_for("s3_fdr_req", 0);
        check("s3_cmp", cmp, 1);
        sb.push_back({17'h300, 8'hCD});
        sb.push_back({17'h301, 8'hAB});
        sb.push_back({17'h302, 8'h01});
        sb.push_back({17'h303, 8'h00});
        fdr(1, 0, 'h1ABCD, 4);
        wait_for("s3_fdr_req2", 0);
        check("s3_fdr_aw", fdr_aw, 4);
        check("s3_here_mid", here, 'h304);
        fdr(1, 1, 'h1ABCD, 8);
        check("s3_exe_req", exe_req, 1);
        check("s3_exe_pfa", exe_pfa, 'h1ABCD);
        exe_ack();
        wait_for("s3_done", 4);
        check("s3_here", here, 'h304);
        check("s3_sb_empty", sb.size(), 0);

        // Parse error
        do_reset();
        start(4, 0, 0);
        wait_for("s4_fdr_req", 0);
        fdr(0, 0, 0, 3);
        wait_for("s4_a2i_req", 1);
        a2i(1, 0, 0);
        check("s4_err", err, 1);
        check("s4_code", err_code, 1);
        check("s4_bsy", bsy, 0);
        check("s4_a2i_drop", a2i_req, 0);
        check("s4_no_psh", n_psh, 0);

        // Interpret a number, then simultaneous set/clear of the compile flag
        do_reset();
        start(4, 0, 0);
        wait_for("s5_fdr_req", 0);
        fdr(0, 0, 0, 3);
        wait_for("s5_a2i_req", 1);
        a2i(0, 'hCAFE, 4);
        wait_for("s5_psh_req", 3);
        check("s5_psh_val", psh_val, 'hCAFE);
        psh_pulse();
        wait_for("s5_done", 4);
        check("s5_err", {err, err_code}, 0);
        set_pulse();
        check("s5_cmp_set", cmp, 1);
        cmp_set = 1'b1; cmp_clr = 1'b1;
        @(negedge clk);
        cmp_set = 1'b0; cmp_clr = 1'b0;
        check("s5_clr_wins", cmp, 0);

        // Asynchronous reset in the middle of compiling a word
        do_reset();
        start(8, 'h400, 0);
        set_pulse();
        wait_for("s6_fdr_req", 0);
        sb.push_back({17'h400, 8'hCD});
        sb.push_back({17'h401, 8'hAB});
        sb.push_back({17'h402, 8'h01});
        fdr(1, 0, 'h1ABCD, 4);
        @(negedge clk);
        @(negedge clk);
        #1 rst = 1'b1; en = 1'b0;
        #1;
        check("s6_mem_we", mem_we, 0);
        check("s6_here", here, 0);
        check("s6_bsy", bsy, 0);
        check("s6_mem", {mem_ai, mem_vi}, 0);
        check("s6_cmp", cmp, 0);
        @(negedge clk);
        rst = 1'b0;
        check("s6_sb_empty", sb.size(), 0);

        // en dropped while a lookup is pending
        do_reset();
        start(8, 'h123, 0);
        wait_for("s7_fdr_req", 0);
        fdr(1, 0, 'h50, 4);
        exe_ack();
        wait_for("s7_fdr_req2", 0);
        en = 1'b0;
        @(negedge clk);
        check("s7_fdr_drop", fdr_req, 0);
        check("s7_bsy", bsy, 0);
        check("s7_here", here, 'h123);
        check("s7_tib", tib, 4);

        check("final_sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
